// File: rtl/round_stream_if.sv
// Handshake bundle between the activation source, the round/saturate sequencer and the packer.
// The slave modport is the sequencer's view; master is the driver/consumer side.
interface round_stream_if #(
    parameter int N       = 16,
    parameter int BIT_IDX = 4,
    parameter int CNT_W   = 16
);
    logic               i_cfg_valid;
    logic [BIT_IDX-1:0] i_n;
    logic [BIT_IDX-1:0] i_offset;
    logic [CNT_W-1:0]   i_count;
    logic               o_cfg_ready;
    logic               i_valid;
    logic [N-1:0]       i_data;
    logic               o_ready;
    logic               o_valid;
    logic [N-1:0]       o_data;
    logic               i_ready;
    logic               o_done;
    logic [CNT_W-1:0]   o_sat_count;

    modport slave (
        input  i_cfg_valid, i_n, i_offset, i_count, i_valid, i_data, i_ready,
        output o_cfg_ready, o_ready, o_valid, o_data, o_done, o_sat_count
    );

    modport master (
        output i_cfg_valid, i_n, i_offset, i_count, i_valid, i_data, i_ready,
        input  o_cfg_ready, o_ready, o_valid, o_data, o_done, o_sat_count
    );
endinterface

// File: rtl/round_stream_ctrl.sv
// Per-layer round-half-up / symmetric-saturate stage: latches a layer config, streams exactly
// i_count words through a 2-stage stall-freezing pipe, counts clamped words, pulses o_done.
module round_stream_ctrl #(
    parameter int N       = 16,
    parameter int BIT_IDX = 4,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    round_stream_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [N:0]       ONE     = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]       ALL1    = {(N+1){1'b1}};
    localparam logic [N:0]       LIM_MAX = {2'b00, {(N-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_next;
    logic [BIT_IDX-1:0] r_n, r_off;
    logic [CNT_W-1:0]   r_in_rem, r_out_rem, r_sat_cnt;
    logic               r_v1, r_valid, r_sat_flag;
    logic [N:0]         r_s1;
    logic [N-1:0]       r_data;

    logic       w_stall, w_ready, w_acc, w_take, w_cfg, w_last_in, w_last_out, w_sat;
    logic [N:0] w_bias, w_s1_in, w_lim, w_nlim, w_clamp, w_mask, w_res;
    int         w_e;

    assign w_stall    = r_valid & ~bus.i_ready;
    assign w_ready    = (r_state == S_RUN) & ~w_stall;
    assign w_acc      = bus.i_valid & w_ready;
    assign w_take     = r_valid & bus.i_ready;
    assign w_cfg      = (r_state == S_IDLE) & bus.i_cfg_valid;
    assign w_last_in  = w_acc & (r_in_rem == CNT_ONE);
    assign w_last_out = w_take & (r_out_rem == CNT_ONE);

    // Half-LSB of the kept precision; shifting back by one makes offset==0 give no bias.
    assign w_bias  = (ONE << r_off) >> 1;
    assign w_s1_in = {bus.i_data[N-1], bus.i_data} + w_bias;

    always_comb begin
        w_e     = int'(r_n) + int'(r_off);
        w_lim   = (w_e >= N - 1) ? LIM_MAX : ((ONE << w_e) - ONE);
        w_nlim  = ~w_lim + ONE;
        w_clamp = r_s1;
        w_sat   = 1'b0;
        if ($signed(r_s1) > $signed(w_lim)) begin
            w_clamp = w_lim;
            w_sat   = 1'b1;
        end else if ($signed(r_s1) < $signed(w_nlim)) begin
            w_clamp = w_nlim;
            w_sat   = 1'b1;
        end
        w_mask = (int'(r_off) >= N) ? '0 : (ALL1 << r_off);
        w_res  = w_clamp & w_mask;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cfg) w_next = (bus.i_count == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last_in) w_next = S_DRAIN;
            S_DRAIN: if (w_last_out) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_off      <= '0;
            r_in_rem   <= '0;
            r_out_rem  <= '0;
            r_sat_cnt  <= '0;
            r_v1       <= 1'b0;
            r_s1       <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cfg) begin
                r_n       <= bus.i_n;
                r_off     <= bus.i_offset;
                r_in_rem  <= bus.i_count;
                r_out_rem <= bus.i_count;
                r_sat_cnt <= '0;
            end
            if (w_acc) r_in_rem <= r_in_rem - CNT_ONE;
            if (w_take) begin
                r_out_rem <= r_out_rem - CNT_ONE;
                if (r_sat_flag && (r_sat_cnt != '1)) r_sat_cnt <= r_sat_cnt + CNT_ONE;
            end
            // Both stages hold together while the packer is not taking the output word.
            if (!w_stall) begin
                r_v1    <= w_acc;
                r_valid <= r_v1;
                if (w_acc) r_s1 <= w_s1_in;
                if (r_v1) begin
                    r_data     <= w_res[N-1:0];
                    r_sat_flag <= w_sat;
                end
            end
        end
    end

    assign bus.o_cfg_ready = (r_state == S_IDLE);
    assign bus.o_ready     = w_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_data      = r_data;
    assign bus.o_done      = (r_state == S_DONE);
    assign bus.o_sat_count = r_sat_cnt;
endmodule

// File: tb/tb_round_stream_ctrl.sv
// Randomized bench for round_stream_ctrl against a queue-based arithmetic reference model.
module tb_round_stream_ctrl;
    localparam int N = 16, BI = 4, CW = 16, LIMIT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    round_stream_if #(.N(N), .BIT_IDX(BI), .CNT_W(CW)) bus();
    round_stream_ctrl #(.N(N), .BIT_IDX(BI), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0, bad = 0;

    // reference model: phase 0 = idle, 1 = layer busy, 2 = done pulse cycle
    int           ph = 0;
    int           m_n, m_off, m_cnt, m_acc, m_taken, m_sat = 0;
    logic [N-1:0] expq[$];
    bit           satq[$];
    logic [N-1:0] got[$];
    logic [N-1:0] din[$];
    bit           m_rdy, prev_stall = 0, s;
    logic [N-1:0] prev_data, v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] rmodel(input logic [N-1:0] d, input int n, input int off,
                                            output bit sat);
        int r, e, lim, res;
        r   = int'($signed(d)) + ((off > 0) ? (1 << (off - 1)) : 0);
        e   = n + off;
        lim = (e >= N - 1) ? ((1 << (N - 1)) - 1) : ((1 << e) - 1);
        sat = 0;
        res = r;
        if (r > lim) begin res = lim; sat = 1; end
        else if (r < -lim) begin res = -lim; sat = 1; end
        if (off >= N) res = 0;
        else res = (res >>> off) <<< off;
        return res[N-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            ph = 0; m_sat = 0; prev_stall = 0;
            expq.delete(); satq.delete();
            chk("rst_o_valid", bus.o_valid, 0);
            chk("rst_o_ready", bus.o_ready, 0);
            chk("rst_o_done", bus.o_done, 0);
            chk("rst_o_data", bus.o_data, 0);
            chk("rst_o_sat_count", bus.o_sat_count, 0);
        end else begin
            chk("o_cfg_ready", bus.o_cfg_ready, ph == 0);
            chk("o_done", bus.o_done, ph == 2);
            chk("o_sat_count", bus.o_sat_count, m_sat);
            m_rdy = (ph == 1) && (m_acc < m_cnt) && !(bus.o_valid && !bus.i_ready);
            chk("o_ready", bus.o_ready, m_rdy);
            if (prev_stall) begin
                chk("hold_valid", bus.o_valid, 1);
                chk("hold_data", bus.o_data, prev_data);
            end
            if (bus.o_valid && expq.size() == 0) chk("unexpected_valid", bus.o_valid, 0);
            case (ph)
                0: if (bus.i_cfg_valid) begin
                    m_n = int'(bus.i_n); m_off = int'(bus.i_offset); m_cnt = int'(bus.i_count);
                    m_acc = 0; m_taken = 0; m_sat = 0;
                    ph = (m_cnt == 0) ? 2 : 1;
                end
                2: ph = 0;
                default: begin
                    if (bus.o_valid && bus.i_ready && expq.size() > 0) begin
                        v = expq.pop_front();
                        s = satq.pop_front();
                        chk("o_data", bus.o_data, v);
                        got.push_back(bus.o_data);
                        m_taken++;
                        if (s && m_sat < (1 << CW) - 1) m_sat++;
                        if (m_taken == m_cnt) ph = 2;
                    end
                    if (bus.i_valid && m_rdy) begin
                        expq.push_back(rmodel(bus.i_data, m_n, m_off, s));
                        satq.push_back(s);
                        m_acc++;
                    end
                end
            endcase
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_data  = bus.o_data;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic cfg(input int n, input int off, input int cnt);
        int t = 0;
        while (!bus.o_cfg_ready && t < LIMIT) begin cyc(); t++; end
        if (t >= LIMIT) begin total++; bad++; $display("FAIL cfg_wait_timeout"); end
        bus.i_valid = 1'b0;
        bus.i_cfg_valid = 1'b1;
        bus.i_n = BI'(n); bus.i_offset = BI'(off); bus.i_count = CW'(cnt);
        cyc();
        bus.i_cfg_valid = 1'b0;
    endtask

    function automatic logic [N-1:0] pick();
        logic [N-1:0] d;
        case ($urandom_range(0, 3))
            0: d = 16'h7FFF - N'($urandom_range(0, 20));
            1: d = 16'h8000 + N'($urandom_range(0, 20));
            default: d = N'($urandom);
        endcase
        return d;
    endfunction

    // vmode 0: i_valid held high; rmode 0: always ready, 1: random, 2: 1,0,0,1 repeating
    task automatic run_layer(input int n, input int off, input int cnt, input int rmode,
                             input int vmode);
        int t = 0;
        bit acc;
        cfg(n, off, cnt);
        while (ph != 0 && t < LIMIT) begin
            bus.i_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.i_data  = (din.size() > 0) ? din[0] : pick();
            case (rmode)
                0: bus.i_ready = 1'b1;
                1: bus.i_ready = ($urandom_range(0, 3) != 0);
                default: bus.i_ready = (t % 4 == 0) || (t % 4 == 3);
            endcase
            bus.i_cfg_valid = ($urandom_range(0, 3) == 0);
            bus.i_n = BI'($urandom); bus.i_offset = BI'($urandom); bus.i_count = CW'($urandom);
            @(negedge clk);
            acc = bus.i_valid && bus.o_ready;
            cyc();
            if (acc && din.size() > 0) void'(din.pop_front());
            t++;
        end
        if (t >= LIMIT) begin total++; bad++; $display("FAIL layer_timeout cnt=%0d", cnt); end
        bus.i_valid = 1'b0; bus.i_cfg_valid = 1'b0; bus.i_ready = 1'b1;
    endtask

    initial begin
        int lat;
        bus.i_cfg_valid = 0; bus.i_n = 0; bus.i_offset = 0; bus.i_count = 0;
        bus.i_valid = 0; bus.i_data = 0; bus.i_ready = 1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // abort mid-layer with two words in flight
        cfg(7, 2, 4);
        bus.i_valid = 1; bus.i_ready = 0; bus.i_data = 16'h0011;
        cyc();
        bus.i_data = 16'h0022;
        cyc();
        bus.i_valid = 0;
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", bus.o_valid, 0);
        chk("async_rst_cfg_ready", bus.o_cfg_ready, 1);
        cyc();
        rst = 1'b0; bus.i_ready = 1;
        @(negedge clk);
        chk("post_rst_cfg_ready", bus.o_cfg_ready, 1);
        chk("post_rst_no_done", bus.o_done, 0);
        cyc();

        // symmetric clamp at +/-7
        got.delete();
        din = {16'h7FFF, 16'h8000, 16'h0007};
        run_layer(3, 0, 3, 0, 0);
        chk("t3_size", got.size(), 3);
        if (got.size() == 3) begin
            chk("t3_w0", got[0], 16'h0007);
            chk("t3_w1", got[1], 16'hFFF9);
            chk("t3_w2", got[2], 16'h0007);
        end
        chk("t3_sat", bus.o_sat_count, 2);

        // round half up with two fractional bits dropped
        got.delete();
        din = {16'h0005, 16'h0006};
        run_layer(7, 2, 2, 0, 0);
        chk("t2_size", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_w0", got[0], 16'h0004);
            chk("t2_w1", got[1], 16'h0008);
        end

        // wide n+offset must not wrap the limit
        got.delete();
        din = {16'h7FFF};
        run_layer(15, 4, 1, 0, 0);
        chk("t4_size", got.size(), 1);
        if (got.size() == 1) chk("t4_w0", got[0], 16'h7FF0);

        // accept -> output latency with no stall
        cfg(7, 2, 1);
        bus.i_valid = 1; bus.i_ready = 1; bus.i_data = 16'h0005;
        @(negedge clk);
        cyc();
        bus.i_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.o_valid && lat < 10);
        chk("latency", lat, 2);
        lat = 0;
        while (ph != 0 && lat < LIMIT) begin cyc(); lat++; end
        cyc();

        // backpressure 1,0,0,1 with random valid
        got.delete();
        run_layer(5, 3, 8, 2, 1);
        chk("t5_count", got.size(), 8);

        // empty layer
        got.delete();
        run_layer(4, 1, 0, 0, 1);
        chk("t6_no_words", got.size(), 0);

        // random layers
        for (int i = 0; i < 30; i++) begin
            got.delete();
            lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
            run_layer($urandom_range(0, 15), $urandom_range(0, 15), lat,
                      $urandom_range(0, 2), $urandom_range(0, 1));
            chk("rand_count", got.size(), lat);
        end

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
